// File: rtl/id_ex_pkg.sv
`default_nettype none
// ============================================================================
// Package     : id_ex_pkg
// Description : Shared constants and types for the ID->EX pipeline boundary.
//               Holds the default payload/control widths, the bit layout of
//               the decoded control word and the skid-buffer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package id_ex_pkg;

  // Default widths: payload {rs1_data,rs2_data,imm,pc,compressed}, control word.
  localparam int unsigned ID_EX_DATA_W = 129;
  localparam int unsigned ID_EX_CTRL_W = 29;

  // Control word layout, MSB to LSB:
  // {rd,rs1,rs2,alu_src,alu_op,jal,jalr,branch,bne,mem_ren,mem_wen,mem_to_reg,
  //  reg_wen,branch_taken}
  localparam int unsigned BRANCH_TAKEN_LSB = 0;
  localparam int unsigned REG_WEN_LSB      = 1;
  localparam int unsigned MEM_TO_REG_LSB   = 2;
  localparam int unsigned MEM_WEN_LSB      = 3;
  localparam int unsigned MEM_REN_LSB      = 4;
  localparam int unsigned BNE_LSB          = 5;
  localparam int unsigned BRANCH_LSB       = 6;
  localparam int unsigned JALR_LSB         = 7;
  localparam int unsigned JAL_LSB          = 8;
  localparam int unsigned ALU_OP_LSB       = 9;
  localparam int unsigned ALU_OP_W         = 4;
  localparam int unsigned ALU_SRC_LSB      = 13;
  localparam int unsigned RS2_LSB          = 14;
  localparam int unsigned RS1_LSB          = 19;
  localparam int unsigned RD_LSB           = 24;
  localparam int unsigned REG_IDX_W        = 5;

  // Occupancy of the skid buffer (head register H, skid register S).
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

endpackage : id_ex_pkg
`default_nettype wire

// File: rtl/id_ex_skid_stage_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter. Sticks at all-ones instead of wrapping;
//               a clear request overrides an increment in the same cycle.
// Ports       : clk, rst_n (async, active-low), inc (count this cycle),
//               clr (synchronous clear), cnt (current value).
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign cnt = r_cnt;

endmodule : sat_counter
`default_nettype wire

// File: rtl/id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_skid_stage
// Description : ID->EX pipeline boundary with valid/ready handshake. With
//               SKID_EN=1 a 2-entry skid buffer registers in_ready so EX
//               back-pressure never reaches IF/ID combinationally; with
//               SKID_EN=0 it is a single stall/flush register. Flush clears
//               only the control field of held entries. Saturating stall and
//               bubble counters are provided for performance tuning.
// Ports       : clk, rst_n (async, active-low), flush,
//               in_valid/in_ready/in_data/in_ctrl   (ID side),
//               out_valid/out_ready/out_data/out_ctrl (EX side),
//               perf_clr, stall_cnt, bubble_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_skid_stage
  import id_ex_pkg::*;
#(
  parameter int DATA_W  = ID_EX_DATA_W,
  parameter int CTRL_W  = ID_EX_CTRL_W,
  parameter int SKID_EN = 1,
  parameter int PERF_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  input  logic              perf_clr,
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] bubble_cnt
);

  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_fire_in;
  logic              w_fire_out;
  logic [DATA_W-1:0] w_head_data;
  logic [CTRL_W-1:0] w_head_ctrl;

  assign w_fire_in  = in_valid & w_in_ready;
  assign w_fire_out = w_out_valid & out_ready;

  if (SKID_EN != 0) begin : g_skid
    skid_state_t       r_state,  w_state_nxt;
    logic [DATA_W-1:0] r_h_data, w_h_data_nxt;
    logic [DATA_W-1:0] r_s_data, w_s_data_nxt;
    logic [CTRL_W-1:0] r_h_ctrl, w_h_ctrl_nxt;
    logic [CTRL_W-1:0] r_s_ctrl, w_s_ctrl_nxt;

    // Depends only on state, so ready is effectively a registered signal.
    assign w_in_ready  = (r_state != FULL);
    assign w_out_valid = (r_state != EMPTY);
    assign w_head_data = r_h_data;
    assign w_head_ctrl = r_h_ctrl;

    always_comb begin
      w_state_nxt  = r_state;
      w_h_data_nxt = r_h_data;
      w_h_ctrl_nxt = r_h_ctrl;
      w_s_data_nxt = r_s_data;
      w_s_ctrl_nxt = r_s_ctrl;
      case (r_state)
        EMPTY: begin
          if (w_fire_in) begin
            w_h_data_nxt = in_data;
            w_h_ctrl_nxt = in_ctrl;
            w_state_nxt  = ONE;
          end
        end
        ONE: begin
          if (w_fire_in && w_fire_out) begin
            w_h_data_nxt = in_data;
            w_h_ctrl_nxt = in_ctrl;
          end else if (w_fire_in) begin
            w_s_data_nxt = in_data;
            w_s_ctrl_nxt = in_ctrl;
            w_state_nxt  = FULL;
          end else if (w_fire_out) begin
            w_state_nxt  = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so nothing can be accepted alongside the shift.
          if (w_fire_out) begin
            w_h_data_nxt = r_s_data;
            w_h_ctrl_nxt = r_s_ctrl;
            w_state_nxt  = ONE;
          end
        end
        default: w_state_nxt = EMPTY;
      endcase
      // Flush drops every entry, including one offered this cycle; payload is
      // left untouched and only the control fields become NOPs.
      if (flush) begin
        w_state_nxt  = EMPTY;
        w_h_data_nxt = r_h_data;
        w_s_data_nxt = r_s_data;
        w_h_ctrl_nxt = '0;
        w_s_ctrl_nxt = '0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_state  <= EMPTY;
        r_h_data <= '0;
        r_h_ctrl <= '0;
        r_s_data <= '0;
        r_s_ctrl <= '0;
      end else begin
        r_state  <= w_state_nxt;
        r_h_data <= w_h_data_nxt;
        r_h_ctrl <= w_h_ctrl_nxt;
        r_s_data <= w_s_data_nxt;
        r_s_ctrl <= w_s_ctrl_nxt;
      end
    end
  end else begin : g_single
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CTRL_W-1:0] r_ctrl;

    // Legacy timing: EX back-pressure passes straight through to ID.
    assign w_in_ready  = out_ready | ~r_valid;
    assign w_out_valid = r_valid;
    assign w_head_data = r_data;
    assign w_head_ctrl = r_ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_data  <= '0;
        r_ctrl  <= '0;
      end else if (flush) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
        if (w_fire_in) begin
          r_data <= in_data;
        end
      end else if (w_fire_in) begin
        r_valid <= 1'b1;
        r_data  <= in_data;
        r_ctrl  <= in_ctrl;
      end else if (w_fire_out) begin
        r_valid <= 1'b0;
        r_ctrl  <= '0;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_head_data;
  // Invalid slots always present a NOP control word to EX.
  assign out_ctrl  = w_out_valid ? w_head_ctrl : '0;

  sat_counter #(.W(PERF_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_out_valid & ~out_ready),
    .clr   (perf_clr),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(PERF_W)) u_bubble_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (~w_out_valid),
    .clr   (perf_clr),
    .cnt   (bubble_cnt)
  );

endmodule : id_ex_skid_stage
`default_nettype wire

// File: tb/tb_id_ex_skid_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_skid_stage
// Description : Directed self-checking bench for id_ex_skid_stage. Three
//               instances share one stimulus: A (skid, 16-bit counters),
//               B (skid, 4-bit counters), C (single register, legacy).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_skid_stage;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic         perf_clr;
  logic [128:0] in_data;
  logic [28:0]  in_ctrl;

  logic ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [128:0] od_a, od_b, od_c;
  logic [28:0]  oc_a, oc_b, oc_c;
  logic [15:0]  st_a, bu_a, st_c, bu_c;
  logic [3:0]   st_b, bu_b;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_ex_skid_stage #(.DATA_W(129), .CTRL_W(29), .SKID_EN(1), .PERF_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov_a), .out_ready(out_ready),
    .out_data(od_a), .out_ctrl(oc_a), .perf_clr(perf_clr), .stall_cnt(st_a),
    .bubble_cnt(bu_a)
  );

  id_ex_skid_stage #(.DATA_W(129), .CTRL_W(29), .SKID_EN(1), .PERF_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov_b), .out_ready(out_ready),
    .out_data(od_b), .out_ctrl(oc_b), .perf_clr(perf_clr), .stall_cnt(st_b),
    .bubble_cnt(bu_b)
  );

  id_ex_skid_stage #(.DATA_W(129), .CTRL_W(29), .SKID_EN(0), .PERF_W(16)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
    .in_data(in_data), .in_ctrl(in_ctrl), .out_valid(ov_c), .out_ready(out_ready),
    .out_data(od_c), .out_ctrl(oc_c), .perf_clr(perf_clr), .stall_cnt(st_c),
    .bubble_cnt(bu_c)
  );

  function automatic logic [128:0] dat(input int n);
    return {65'h1_DEAD_BEEF_CAFE_F00D, 32'hA5A5_0000, 32'(n)};
  endfunction

  function automatic logic [28:0] ctl(input int n);
    return 29'h1000_0000 | 29'(n);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input int n);
    in_valid = 1'b1;
    in_data  = dat(n);
    in_ctrl  = ctl(n);
  endtask

  task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; perf_clr = 1'b0;
    in_data = '0; in_ctrl = '0;

    // Reset state
    tick(); tick();
    chk("rst_out_valid",  129'(ov_a), 129'(0));
    chk("rst_out_ctrl",   129'(oc_a), 129'(0));
    chk("rst_out_data",   od_a, 129'(0));
    chk("rst_in_ready",   129'(ir_a), 129'(1));
    chk("rst_stall_a",    129'(st_a), 129'(0));
    chk("rst_bubble_a",   129'(bu_a), 129'(0));
    chk("rst_stall_c",    129'(st_c), 129'(0));
    chk("rst_bubble_c",   129'(bu_c), 129'(0));
    rst_n = 1'b1;
    perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    chk("clr_bubble_a",   129'(bu_a), 129'(0));

    // 1: stream of 8 with out_ready=1, one-cycle latency, strict order
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      offer(i);
      tick();
      chk("t1_valid", 129'(ov_a), 129'(1));
      chk("t1_data",  od_a, dat(i));
      chk("t1_ctrl",  129'(oc_a), 129'(ctl(i)));
      chk("t1_ready", 129'(ir_a), 129'(1));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_bubble_stops", 129'(bu_a), 129'(1));
    chk("t1_drained",      129'(ov_a), 129'(0));
    chk("t1_nop_ctrl",     129'(oc_a), 129'(0));
    chk("t1_data_held",    od_a, dat(7));

    // 2: fill, stall 4 cycles, drain
    out_ready = 1'b0; perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    offer(10); tick();
    chk("t2_one_ready", 129'(ir_a), 129'(1));
    offer(11); tick();
    chk("t2_full_ready", 129'(ir_a), 129'(0));
    chk("t2_full_head",  od_a, dat(10));
    offer(12);
    repeat (3) tick();
    chk("t2_stall4",     129'(st_a), 129'(4));
    chk("t2_still_full", 129'(ir_a), 129'(0));
    out_ready = 1'b1; in_valid = 1'b0; tick();
    chk("t2_second",     od_a, dat(11));
    chk("t2_second_c",   129'(oc_a), 129'(ctl(11)));
    chk("t2_ready_back", 129'(ir_a), 129'(1));
    chk("t2_stall_hold", 129'(st_a), 129'(4));
    tick();
    chk("t2_empty",      129'(ov_a), 129'(0));

    // 3: flush in FULL with an offer, then flush with fire_out
    out_ready = 1'b0;
    offer(20); tick();
    offer(21); tick();
    chk("t3_full", 129'(ir_a), 129'(0));
    flush = 1'b1; offer(22); tick();
    chk("t3_fl_valid", 129'(ov_a), 129'(0));
    chk("t3_fl_ctrl",  129'(oc_a), 129'(0));
    chk("t3_fl_data",  od_a, dat(20));
    chk("t3_fl_ready", 129'(ir_a), 129'(1));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    chk("t3_no_ghost", 129'(ov_a), 129'(0));
    out_ready = 1'b0; offer(30); tick();
    flush = 1'b1; out_ready = 1'b1; offer(31); #1;
    chk("t3_fo_valid", 129'(ov_a), 129'(1));
    chk("t3_fo_data",  od_a, dat(30));
    tick();
    chk("t3_fo_gone",  129'(ov_a), 129'(0));
    flush = 1'b0; in_valid = 1'b0; tick();
    chk("t3_fo_once",  129'(ov_a), 129'(0));

    // 4: counter saturation on the 4-bit instance
    out_ready = 1'b0; perf_clr = 1'b1; tick(); perf_clr = 1'b0;
    offer(40); tick();
    in_valid = 1'b0;
    repeat (20) tick();
    chk("t4_sat_b",   129'(st_b), 129'(15));
    chk("t4_wide_a",  129'(st_a), 129'(20));
    chk("t4_b_valid", 129'(ov_b), 129'(1));
    chk("t4_b_data",  od_b, dat(40));
    chk("t4_b_ctrl",  129'(oc_b), 129'(ctl(40)));
    chk("t4_b_ready", 129'(ir_b), 129'(1));
    chk("t4_b_bub",   129'(bu_b), 129'(1));
    perf_clr = 1'b1; tick();
    chk("t4_clr_b",   129'(st_b), 129'(0));
    chk("t4_clr_a",   129'(st_a), 129'(0));
    perf_clr = 1'b0; tick();
    chk("t4_recount", 129'(st_b), 129'(1));
    out_ready = 1'b1; tick();

    // 5: asynchronous reset while FULL
    out_ready = 1'b0;
    offer(50); tick();
    offer(51); tick();
    chk("t5_full", 129'(ir_a), 129'(0));
    in_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_valid",  129'(ov_a), 129'(0));
    chk("t5_rst_ctrl",   129'(oc_a), 129'(0));
    chk("t5_rst_data",   od_a, 129'(0));
    chk("t5_rst_stall",  129'(st_a), 129'(0));
    chk("t5_rst_bubble", 129'(bu_a), 129'(0));
    chk("t5_rst_ready",  129'(ir_a), 129'(1));
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_clean",      129'(ov_a), 129'(0));
    out_ready = 1'b1; offer(60); tick();
    chk("t5_resume",     od_a, dat(60));
    chk("t5_resume_v",   129'(ov_a), 129'(1));
    in_valid = 1'b0; tick();
    chk("t5_drain",      129'(ov_a), 129'(0));

    // 6: legacy single register on instance C
    out_ready = 1'b0; offer(70); #1;
    chk("t6_empty_ready", 129'(ir_c), 129'(1));
    tick();
    chk("t6_ready_comb0", 129'(ir_c), 129'(0));
    chk("t6_loaded",      od_c, dat(70));
    out_ready = 1'b1; #1;
    chk("t6_ready_comb1", 129'(ir_c), 129'(1));
    out_ready = 1'b0; offer(71); #1;
    chk("t6_ready_comb2", 129'(ir_c), 129'(0));
    tick();
    chk("t6_hold_data",   od_c, dat(70));
    chk("t6_hold_ctrl",   129'(oc_c), 129'(ctl(70)));
    flush = 1'b1; offer(72); tick();
    chk("t6_fl_valid",    129'(ov_c), 129'(0));
    chk("t6_fl_ctrl",     129'(oc_c), 129'(0));
    chk("t6_fl_data",     od_c, dat(70));
    offer(73); tick();
    chk("t6_fl_in_valid", 129'(ov_c), 129'(0));
    chk("t6_fl_in_data",  od_c, dat(73));
    flush = 1'b0; out_ready = 1'b1; offer(74); tick();
    chk("t6_next_valid",  129'(ov_c), 129'(1));
    chk("t6_next_data",   od_c, dat(74));
    chk("t6_next_ctrl",   129'(oc_c), 129'(ctl(74)));
    in_valid = 1'b0; tick();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule : tb_id_ex_skid_stage
`default_nettype wire
